// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core data port bundle between the core (master) and the RAM responder (slave)
interface data_mem_responder_if;
    logic [31:0] data_addr_i;
    logic [31:0] data_data_i;
    logic [1:0]  data_sel_i;
    logic        data_we_i;
    logic        data_rd_i;
    logic [31:0] data_data_o;
    logic        data_valid_o;
    logic        data_fault_o;

    modport master (
        output data_addr_i, data_data_i, data_sel_i, data_we_i, data_rd_i,
        input  data_data_o, data_valid_o, data_fault_o
    );

    modport slave (
        input  data_addr_i, data_data_i, data_sel_i, data_we_i, data_rd_i,
        output data_data_o, data_valid_o, data_fault_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM responder for core loads/stores with programmable wait states
// Optional macro DATA_ALIGN_CHECK_EN: fault misaligned/reserved accesses instead of masking.
module data_mem_responder #(
    parameter int    ADDR_WIDTH  = 10,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           wdata;
    logic [1:0]            sel;
    logic                  we;
    logic                  rd;
    logic [31:0]           data_q;
    logic                  fault_q;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic        req;
    logic        access;
    logic        bad;
    logic [1:0]  eff_lane;
    logic [1:0]  eff_sel;
    logic [3:0]  be;
    logic [31:0] wlanes;
    logic [31:0] rword;
    logic [31:0] rdata;
    logic        unused_addr;

    assign req         = bus.data_rd_i | bus.data_we_i;
    assign access      = (state == S_BUSY) && (cnt == 4'd0);
    assign unused_addr = ^bus.data_addr_i[31:ADDR_WIDTH+2];

`ifdef DATA_ALIGN_CHECK_EN
    assign bad      = (sel == 2'b11) || (sel == 2'b01 && lane[0]) || (sel == 2'b10 && lane != 2'b00);
    assign eff_lane = lane;
    assign eff_sel  = sel;
`else
    // Force natural alignment; the reserved size behaves as a word.
    assign bad      = 1'b0;
    assign eff_sel  = (sel == 2'b11) ? 2'b10 : sel;
    assign eff_lane = (eff_sel == 2'b00) ? lane :
                      (eff_sel == 2'b01) ? {lane[1], 1'b0} : 2'b00;
`endif

    assign rword = mem[idx];

    always_comb begin
        be     = 4'b1111;
        wlanes = wdata;
        rdata  = rword;
        case (eff_sel)
            2'b00: begin
                be     = 4'b0001 << eff_lane;
                wlanes = {4{wdata[7:0]}};
                rdata  = {24'd0, rword[eff_lane*8 +: 8]};
            end
            2'b01: begin
                be     = eff_lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
                rdata  = {16'd0, eff_lane[1] ? rword[31:16] : rword[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (access && we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wlanes[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            idx     <= '0;
            lane    <= 2'd0;
            wdata   <= 32'd0;
            sel     <= 2'd0;
            we      <= 1'b0;
            rd      <= 1'b0;
            data_q  <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    fault_q <= 1'b0;
                    if (req) begin
                        idx   <= bus.data_addr_i[ADDR_WIDTH+1:2];
                        lane  <= bus.data_addr_i[1:0];
                        wdata <= bus.data_data_i;
                        sel   <= bus.data_sel_i;
                        we    <= bus.data_we_i;
                        rd    <= bus.data_rd_i;
                        cnt   <= WAIT_INIT;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_DONE;
                        if (bad) begin
                            data_q  <= 32'd0;
                            fault_q <= 1'b1;
                        end else if (we && rd) begin
                            data_q <= 32'd0;
                        end else if (!we) begin
                            data_q <= rdata;
                        end
                    end
                end
                S_DONE: begin
                    fault_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_data_o  = data_q;
    assign bus.data_fault_o = fault_q;
    assign bus.data_valid_o = ((state == S_IDLE) && !req) || (state == S_DONE);
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (directed vectors)
module tb_data_mem_responder;
`ifdef DATA_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if m ();
    data_mem_responder_if l0 ();
    data_mem_responder_if l3 ();

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_main (.clk(clk), .rst(rst), .bus(m));
    data_mem_responder #(.ADDR_WIDTH(4),  .WAIT_CYCLES(0)) u_w0   (.clk(clk), .rst(rst), .bus(l0));
    data_mem_responder #(.ADDR_WIDTH(4),  .WAIT_CYCLES(3)) u_w3   (.clk(clk), .rst(rst), .bus(l3));

    typedef struct {
        logic [31:0] d;
        logic        f;
        int          tag;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic        prev_valid = 1'b1;
    logic [31:0] last = 32'd0;

    // Completion = rising edge of valid (DONE always follows a low BUSY cycle).
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && m.data_valid_o && !prev_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_completion data=%h fault=%b", m.data_data_o, m.data_fault_o);
            end else begin
                e = sbq.pop_front();
                if (m.data_data_o !== e.d || m.data_fault_o !== e.f) begin
                    failures++;
                    $display("FAIL access_%0d data=%h fault=%b expected data=%h fault=%b",
                             e.tag, m.data_data_o, m.data_fault_o, e.d, e.f);
                end
            end
        end
        prev_valid = m.data_valid_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        #1;
        m.data_we_i = 1'b0;
        m.data_rd_i = 1'b0;
        @(negedge clk);
    endtask

    // Starts at a negedge; returns at the negedge where the access is in DONE.
    task automatic access(input int tag, input logic we, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sel, input logic [31:0] exp_d,
                          input logic exp_f, input int exp_lat, input bit glitch);
        exp_t e;
        int   cyc;
        #1;
        m.data_addr_i = addr;
        m.data_data_i = wd;
        m.data_sel_i  = sel;
        m.data_we_i   = we;
        m.data_rd_i   = rd;
        e.d = exp_d; e.f = exp_f; e.tag = tag;
        sbq.push_back(e);
        last = exp_d;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (m.data_valid_o) break;
            if (glitch && cyc == 1) begin
                #1;
                m.data_addr_i = 32'h10;
                m.data_rd_i   = 1'b0;
            end
            if (cyc > 20) break;
        end
        check($sformatf("latency_%0d", tag), 32'(cyc), 32'(exp_lat));
    endtask

    task automatic lat_test(input int which, input int exp_lat);
        int cyc;
        #1;
        if (which == 0) l0.data_rd_i = 1'b1; else l3.data_rd_i = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if ((which == 0) ? l0.data_valid_o : l3.data_valid_o) break;
            if (cyc > 20) break;
        end
        #1;
        l0.data_rd_i = 1'b0;
        l3.data_rd_i = 1'b0;
        check($sformatf("wait_latency_%0d", which), 32'(cyc), 32'(exp_lat));
        @(negedge clk);
    endtask

    initial begin
        m.data_addr_i = 32'd0; m.data_data_i = 32'd0; m.data_sel_i = 2'd0;
        m.data_we_i = 1'b0; m.data_rd_i = 1'b0;
        l0.data_addr_i = 32'd0; l0.data_data_i = 32'd0; l0.data_sel_i = 2'b10;
        l0.data_we_i = 1'b0; l0.data_rd_i = 1'b0;
        l3.data_addr_i = 32'd0; l3.data_data_i = 32'd0; l3.data_sel_i = 2'b10;
        l3.data_we_i = 1'b0; l3.data_rd_i = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_valid", 32'(m.data_valid_o), 32'd1);
        check("reset_data",  m.data_data_o, 32'd0);
        check("reset_fault", 32'(m.data_fault_o), 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        access(1,  1, 0, 32'h10,   32'hDEADBEEF, 2'b10, last,         0, 3, 0); idle();
        access(2,  0, 1, 32'h10,   32'h0,        2'b10, 32'hDEADBEEF, 0, 3, 0); idle();
        access(3,  1, 0, 32'h20,   32'h11223344, 2'b10, last,         0, 3, 0); idle();
        access(4,  1, 0, 32'h23,   32'h123456AA, 2'b00, last,         0, 3, 0); idle();
        access(5,  0, 1, 32'h20,   32'h0,        2'b10, 32'hAA223344, 0, 3, 0); idle();
        access(6,  0, 1, 32'h23,   32'h0,        2'b00, 32'h000000AA, 0, 3, 0); idle();
        access(7,  0, 1, 32'h22,   32'h0,        2'b01, 32'h0000AA22, 0, 3, 0); idle();
        access(8,  0, 1, 32'h20,   32'h0,        2'b01, 32'h00003344, 0, 3, 0); idle();
        access(9,  0, 1, 32'h21,   32'h0,        2'b00, 32'h00000033, 0, 3, 0); idle();
        access(10, 0, 1, 32'h1010, 32'h0,        2'b10, 32'hDEADBEEF, 0, 3, 0); idle();
        access(11, 1, 0, 32'h4,    32'h55667788, 2'b10, last,         0, 3, 0); idle();
        access(12, 0, 1, 32'h6,    32'h0,        2'b10, ALIGN ? 32'h0 : 32'h55667788, ALIGN, 3, 0); idle();
        access(13, 0, 1, 32'h4,    32'h0,        2'b11, ALIGN ? 32'h0 : 32'h55667788, ALIGN, 3, 0); idle();
        access(14, 0, 1, 32'h23,   32'h0,        2'b01, ALIGN ? 32'h0 : 32'h0000AA22, ALIGN, 3, 0); idle();
        access(15, 1, 0, 32'h0,    32'h0A0B0C0D, 2'b10, last,         0, 3, 0); idle();
        access(16, 0, 1, 32'h0,    32'h0,        2'b10, 32'h0A0B0C0D, 0, 3, 0);
        access(17, 0, 1, 32'h4,    32'h0,        2'b10, 32'h55667788, 0, 4, 0); idle();
        access(18, 1, 1, 32'h8,    32'hCAFEF00D, 2'b10, 32'h0,        0, 3, 0); idle();
        access(19, 0, 1, 32'h8,    32'h0,        2'b10, 32'hCAFEF00D, 0, 3, 0); idle();
        access(20, 1, 0, 32'h12,   32'hFFFF1234, 2'b01, last,         0, 3, 0); idle();
        access(21, 0, 1, 32'h10,   32'h0,        2'b10, 32'h1234BEEF, 0, 3, 0); idle();
        access(22, 0, 1, 32'h20,   32'h0,        2'b10, 32'hAA223344, 0, 3, 1); idle();
        repeat (2) @(negedge clk);

        // Reset while a store is in BUSY: the store must be lost.
        mon_en = 1'b0;
        #1;
        m.data_addr_i = 32'h10; m.data_data_i = 32'h99999999; m.data_sel_i = 2'b10;
        m.data_we_i = 1'b1; m.data_rd_i = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        m.data_we_i = 1'b0;
        #1;
        check("midbusy_reset_valid", 32'(m.data_valid_o), 32'd1);
        check("midbusy_reset_data",  m.data_data_o, 32'd0);
        check("midbusy_reset_fault", 32'(m.data_fault_o), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        last = 32'd0;
        mon_en = 1'b1;
        access(23, 0, 1, 32'h10, 32'h0, 2'b10, 32'h1234BEEF, 0, 3, 0); idle();

        lat_test(0, 2);
        lat_test(3, 5);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
